timing_sequencer: RTL and testbench

Parametrised timed-instruction sequencer that executes 64-bit words from an instruction FIFO. Each word holds an output state for an exact number of clock cycles, drives a TTL bank of configurable width, and pushes loop-back or trigger-timestamp results. New in this generation: masked set/clear TTL updates, a wait-for-trigger instruction with timeout and elapsed-time readback, and a parametrised minimum instruction duration. It sits between the bus-side instruction FIFO and the lab TTL outputs.

---
 rtl/timing_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_timing_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : timing_sequencer
//  Purpose  : Timed-instruction sequencer. Executes 64-bit words from an
//             instruction FIFO, holding each TTL state for an exact number
//             of cycles, with masked set/clear, result pushes and a
//             wait-for-trigger instruction with timeout readback.
//  Revision : 1.0 - initial release
// ============================================================================
module timing_sequencer #(
    parameter int TTL_WIDTH    = 32,
    parameter int TIMER_WIDTH  = 24,
    parameter int MIN_DURATION = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 start_hold,
    input  logic                 inst_fifo_full,
    input  logic                 inst_valid,
    input  logic [63:0]          inst_data,
    output logic                 inst_ready,
    input  logic                 trigger_in,
    output logic [TTL_WIDTH-1:0] ttl_out,
    output logic                 underflow,
    output logic                 finished,
    output logic [31:0]          result_data,
    output logic                 result_valid
);

    localparam logic [3:0]  OP_OUTPUT = 4'd0;
    localparam logic [3:0]  OP_SET    = 4'd1;
    localparam logic [3:0]  OP_CLEAR  = 4'd2;
    localparam logic [3:0]  OP_WAIT   = 4'd3;
    localparam logic [3:0]  OP_CLR_UF = 4'd4;
    localparam logic [3:0]  OP_PUSH   = 4'd5;
    localparam logic [3:0]  OP_TRIG   = 4'd6;
    localparam logic [31:0] MIN_DUR   = 32'(MIN_DURATION);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_COUNT  = 2'd2,
        S_TRIG   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;

    // Latched instruction fields
    logic [3:0]             opcode;
    logic                   check_bit;
    logic [TIMER_WIDTH-1:0] duration;
    logic [31:0]            operand;

    logic [TIMER_WIDTH-1:0] timer;
    logic [30:0]            elapsed;
    logic                   timing_check;
    logic                   running;
    logic                   sync1;
    logic                   sync2;
    logic                   trig_prev;

    logic                   accept;
    logic                   edge_seen;
    logic                   trig_timeout;
    logic                   trig_exit;
    logic                   uses_duration;
    logic [31:0]            dur_ext;
    logic [31:0]            eff_dur;
    logic [TIMER_WIDTH-1:0] timer_load;
    logic                   unused_word;

    // Only some instruction bits are latched; the rest are reserved.
    assign unused_word = ^inst_data;

    assign inst_ready = (state == S_FETCH) & running & ~init;
    assign accept     = inst_valid & inst_ready;

    // State register; init abandons any in-flight instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else if (init) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus duration and trigger-exit decoding.
    always_comb begin
        state_next    = state;
        dur_ext       = 32'(duration);
        uses_duration = (opcode <= OP_WAIT) || (opcode == OP_PUSH);
        eff_dur       = (uses_duration && (dur_ext > MIN_DUR)) ? dur_ext : MIN_DUR;
        // FETCH and DECODE consume two cycles of the period, the last COUNT cycle one more.
        timer_load    = TIMER_WIDTH'(eff_dur - 32'd3);
        edge_seen     = sync2 & ~trig_prev;
        trig_timeout  = (duration == '0) || (elapsed == (31'(dur_ext) - 31'd1));
        trig_exit     = edge_seen | trig_timeout;
        case (state)
            S_FETCH:  if (accept) state_next = S_DECODE;
            S_DECODE: state_next = (opcode == OP_TRIG) ? S_TRIG : S_COUNT;
            S_COUNT:  if (timer == '0) state_next = S_FETCH;
            S_TRIG:   if (trig_exit) state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Trigger synchroniser and edge-detect history; free-running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            sync1     <= trigger_in;
            sync2     <= sync1;
            trig_prev <= sync2;
        end
    end

    // Datapath: instruction latch, TTL bank, timers, flags and result push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode       <= 4'd0;
            check_bit    <= 1'b0;
            duration     <= '0;
            operand      <= 32'd0;
            timer        <= '0;
            elapsed      <= 31'd0;
            timing_check <= 1'b0;
            running      <= 1'b0;
            finished     <= 1'b1;
            underflow    <= 1'b0;
            ttl_out      <= '0;
            result_data  <= 32'd0;
            result_valid <= 1'b0;
        end else if (init) begin
            // Soft restart: TTL bank and last result are deliberately kept.
            timer        <= '0;
            elapsed      <= 31'd0;
            timing_check <= 1'b0;
            running      <= 1'b0;
            finished     <= 1'b1;
            underflow    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (!start_hold || inst_fifo_full) begin
                running <= 1'b1;
            end
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        opcode    <= inst_data[63:60];
                        check_bit <= inst_data[59];
                        duration  <= inst_data[32+TIMER_WIDTH-1:32];
                        operand   <= inst_data[31:0];
                        finished  <= 1'b0;
                    end else begin
                        finished  <= 1'b1;
                        underflow <= underflow | timing_check;
                    end
                end
                S_DECODE: begin
                    timing_check <= check_bit;
                    case (opcode)
                        OP_OUTPUT: ttl_out   <= operand[TTL_WIDTH-1:0];
                        OP_SET:    ttl_out   <= ttl_out | operand[TTL_WIDTH-1:0];
                        OP_CLEAR:  ttl_out   <= ttl_out & ~operand[TTL_WIDTH-1:0];
                        OP_CLR_UF: underflow <= 1'b0;
                        OP_PUSH: begin
                            result_data  <= operand;
                            result_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (opcode == OP_TRIG) begin
                        elapsed <= 31'd0;
                    end else begin
                        timer <= timer_load;
                    end
                end
                S_COUNT: begin
                    if (timer != '0) begin
                        timer <= timer - TIMER_WIDTH'(1);
                    end
                end
                S_TRIG: begin
                    elapsed <= elapsed + 31'd1;
                    if (trig_exit) begin
                        result_data  <= {~edge_seen, elapsed};
                        result_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timing_sequencer
//  Purpose  : Directed self-checking bench for timing_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timing_sequencer;

    localparam int TTL_W = 8;
    localparam int TIM_W = 24;
    localparam int MIN_D = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             init;
    logic             start_hold;
    logic             inst_fifo_full;
    logic             inst_valid;
    logic [63:0]      inst_data;
    logic             inst_ready;
    logic             trigger_in;
    logic [TTL_W-1:0] ttl_out;
    logic             underflow;
    logic             finished;
    logic [31:0]      result_data;
    logic             result_valid;

    timing_sequencer #(
        .TTL_WIDTH   (TTL_W),
        .TIMER_WIDTH (TIM_W),
        .MIN_DURATION(MIN_D)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .init          (init),
        .start_hold    (start_hold),
        .inst_fifo_full(inst_fifo_full),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_ready    (inst_ready),
        .trigger_in    (trigger_in),
        .ttl_out       (ttl_out),
        .underflow     (underflow),
        .finished      (finished),
        .result_data   (result_data),
        .result_valid  (result_valid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic tc,
                                       input logic [23:0] d, input logic [31:0] v);
        return {op, tc, 3'b000, d, v};
    endfunction

    // Bench-side instruction FIFO model
    logic [63:0] fifo_q[$];
    int          accepts = 0;

    initial begin
        logic acc;
        inst_valid = 1'b0;
        inst_data  = 64'd0;
        forever begin
            @(negedge clock);
            #1;
            acc = inst_valid && inst_ready;
            @(posedge clock);
            #1;
            if (acc) begin
                void'(fifo_q.pop_front());
                accepts++;
            end
            if (fifo_q.size() > 0) begin
                inst_valid = 1'b1;
                inst_data  = fifo_q[0];
            end else begin
                inst_valid = 1'b0;
            end
        end
    end

    // Result capture and pulse-width watch
    logic [31:0] res_q[$];
    int          rv_long = 0;
    initial begin
        logic prev_rv;
        prev_rv = 1'b0;
        forever begin
            @(negedge clock);
            if (result_valid) begin
                res_q.push_back(result_data);
                if (prev_rv) rv_long++;
            end
            prev_rv = result_valid;
        end
    end

    logic [31:0] chg_val[$];
    int          chg_cyc[$];

    // Run until FIFO drained and sequencer idle, logging every TTL change.
    task automatic run_idle(input string tag, input int maxc);
        logic [TTL_W-1:0] prev;
        logic             done;
        done = 1'b0;
        chg_val.delete();
        chg_cyc.delete();
        prev = ttl_out;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clock);
            if (ttl_out !== prev) begin
                chg_val.push_back(32'(ttl_out));
                chg_cyc.push_back(cyc);
            end
            prev = ttl_out;
            if (fifo_q.size() == 0 && !inst_valid && finished) done = 1'b1;
        end
        check_eq({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic wait_accepts(input string tag, input int target, input int maxc);
        int n;
        n = 0;
        while (accepts < target && n < maxc) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_accept"}, 32'(accepts >= target), 32'd1);
    endtask

    task automatic wait_result(input string tag, input int target, input int maxc);
        int n;
        n = 0;
        while (res_q.size() < target && n < maxc) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_result"}, 32'(res_q.size() >= target), 32'd1);
    endtask

    initial begin
        int a0;
        int r0;
        reset          = 1'b1;
        init           = 1'b0;
        start_hold     = 1'b1;
        inst_fifo_full = 1'b0;
        trigger_in     = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        check_eq("rst_ttl",      32'(ttl_out),      32'h0);
        check_eq("rst_underflow", 32'(underflow),   32'h0);
        check_eq("rst_finished", 32'(finished),     32'h1);
        check_eq("rst_rvalid",   32'(result_valid), 32'h0);
        check_eq("rst_rdata",    result_data,       32'h0);
        check_eq("rst_ready",    32'(inst_ready),   32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("hold_ready", 32'(inst_ready), 32'h0);
        start_hold = 1'b0;

        // Durations: long word, short word clamped to the minimum
        fifo_q.push_back(mk(4'd0, 1'b0, 24'd10, 32'h123456A5));
        fifo_q.push_back(mk(4'd0, 1'b0, 24'd2,  32'h0000005A));
        fifo_q.push_back(mk(4'd0, 1'b0, 24'd4,  32'h0000003C));
        run_idle("t1", 200);
        check_eq("t1_nchg", 32'(chg_val.size()), 32'd3);
        if (chg_val.size() >= 3) begin
            check_eq("t1_v0", chg_val[0], 32'hA5);
            check_eq("t1_v1", chg_val[1], 32'h5A);
            check_eq("t1_v2", chg_val[2], 32'h3C);
            check_eq("t1_a5_len", 32'(chg_cyc[1] - chg_cyc[0]), 32'd10);
            check_eq("t1_5a_len", 32'(chg_cyc[2] - chg_cyc[1]), 32'd4);
        end
        check_eq("t1_finished", 32'(finished), 32'h1);

        // Masked set/clear
        fifo_q.push_back(mk(4'd0, 1'b0, 24'd5, 32'h000000F0));
        fifo_q.push_back(mk(4'd1, 1'b0, 24'd5, 32'h0000000F));
        fifo_q.push_back(mk(4'd2, 1'b0, 24'd5, 32'h00000081));
        run_idle("t2", 200);
        check_eq("t2_nchg", 32'(chg_val.size()), 32'd3);
        if (chg_val.size() >= 3) begin
            check_eq("t2_out",   chg_val[0], 32'hF0);
            check_eq("t2_set",   chg_val[1], 32'hFF);
            check_eq("t2_clear", chg_val[2], 32'h7E);
        end
        check_eq("t2_underflow", 32'(underflow), 32'h0);

        // Timing check underflow and its clear
        fifo_q.push_back(mk(4'd3, 1'b1, 24'd5, 32'h00000000));
        run_idle("t3", 100);
        check_eq("t3_uf_set",  32'(underflow), 32'h1);
        check_eq("t3_wait_ttl", 32'(ttl_out),  32'h7E);
        fifo_q.push_back(mk(4'd4, 1'b0, 24'd0, 32'h00000000));
        run_idle("t3c", 100);
        check_eq("t3_uf_clr", 32'(underflow), 32'h0);

        // Result push
        r0 = res_q.size();
        fifo_q.push_back(mk(4'd5, 1'b0, 24'd4, 32'hDEADBEEF));
        wait_result("push", r0 + 1, 50);
        if (res_q.size() > r0) check_eq("push_val", res_q[r0], 32'hDEADBEEF);
        run_idle("push", 50);
        check_eq("push_hold", result_data, 32'hDEADBEEF);

        // Trigger seen: input rises while elapsed is 20, synchronised edge seen at 22
        r0 = res_q.size();
        a0 = accepts;
        fifo_q.push_back(mk(4'd6, 1'b0, 24'd100, 32'h0));
        wait_accepts("trig", a0 + 1, 50);
        repeat (21) @(negedge clock);
        trigger_in = 1'b1;
        repeat (3) @(negedge clock);
        trigger_in = 1'b0;
        wait_result("trig", r0 + 1, 200);
        if (res_q.size() > r0) check_eq("trig_hit", res_q[r0], 32'h00000016);

        // Trigger timeout
        r0 = res_q.size();
        fifo_q.push_back(mk(4'd6, 1'b0, 24'd100, 32'h0));
        wait_result("tmo", r0 + 1, 300);
        if (res_q.size() > r0) check_eq("trig_timeout", res_q[r0], 32'h80000063);

        // Zero-duration trigger times out at once
        r0 = res_q.size();
        fifo_q.push_back(mk(4'd6, 1'b0, 24'd0, 32'h0));
        wait_result("tmo0", r0 + 1, 50);
        if (res_q.size() > r0) check_eq("trig_d0", res_q[r0], 32'h80000000);
        run_idle("tmo0", 50);
        check_eq("rv_one_cycle", 32'(rv_long), 32'd0);

        // start_hold keeps queued words pending until FIFO-full release
        start_hold = 1'b1;
        init       = 1'b1;
        @(negedge clock);
        init = 1'b0;
        a0 = accepts;
        fifo_q.push_back(mk(4'd0, 1'b0, 24'd4, 32'h11));
        fifo_q.push_back(mk(4'd0, 1'b0, 24'd4, 32'h22));
        repeat (20) @(negedge clock);
        check_eq("hold_ttl",     32'(ttl_out),    32'h7E);
        check_eq("hold_accepts", 32'(accepts - a0), 32'd0);
        check_eq("hold_ready2",  32'(inst_ready), 32'h0);
        inst_fifo_full = 1'b1;
        @(negedge clock);
        inst_fifo_full = 1'b0;
        run_idle("full", 100);
        check_eq("full_ttl",     32'(ttl_out),      32'h22);
        check_eq("full_accepts", 32'(accepts - a0), 32'd2);

        // init mid-WAIT
        a0 = accepts;
        fifo_q.push_back(mk(4'd0, 1'b0, 24'd4,  32'h77));
        fifo_q.push_back(mk(4'd3, 1'b0, 24'd50, 32'h00));
        wait_accepts("init", a0 + 2, 100);
        repeat (10) @(negedge clock);
        check_eq("init_pre_fin", 32'(finished), 32'h0);
        init = 1'b1;
        @(negedge clock);
        init = 1'b0;
        check_eq("init_ttl",   32'(ttl_out),    32'h77);
        check_eq("init_fin",   32'(finished),   32'h1);
        check_eq("init_ready", 32'(inst_ready), 32'h0);
        check_eq("init_rdata", result_data,     32'h80000000);
        repeat (5) @(negedge clock);
        check_eq("init_ttl_hold", 32'(ttl_out),  32'h77);
        check_eq("init_fin_hold", 32'(finished), 32'h1);

        // Asynchronous reset clears the TTL bank
        reset = 1'b1;
        #1;
        check_eq("reset_ttl",   32'(ttl_out), 32'h0);
        check_eq("reset_rdata", result_data,  32'h0);
        @(negedge clock);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
